// File: rtl/mode_sequencer.sv
// Video mode sequencer: debounced "next mode" button steps the mode index, then
// pulses a PLL reconfiguration request and waits (with timeout) for lock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// START      | first cycle after reset, programs the reset mode
// PULSE      | mode_change asserted for one cycle, mode already updated
// SETTLE     | fixed wait before pll_locked is trusted
// WAIT_LOCK  | wait for lock, bounded by LOCK_TIMEOUT
// IDLE       | quiescent, accepts press events
module mode_sequencer #(
    parameter int NUM_MODES       = 6,
    parameter int INIT_INDEX      = 0,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 64,
    parameter int LOCK_TIMEOUT    = 5000000
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       pll_locked,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       busy,
    output logic       lock_err
);

    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int WAIT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_START,
        ST_PULSE,
        ST_SETTLE,
        ST_WAIT_LOCK,
        ST_IDLE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_btn_s1;
    logic               r_btn_s2;
    logic               r_lock_s1;
    logic               r_lock_s2;
    logic               r_btn_db;
    logic [DB_W-1:0]    r_db_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [3:0]         r_mode;
    logic               r_lock_err;

    logic               w_btn_diff;
    logic               w_db_tc;
    logic               w_press;
    logic               w_settle_tc;
    logic               w_lock_tc;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_mode_adv;
    logic               w_err_set;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_s1  <= 1'b1;
            r_btn_s2  <= 1'b1;
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_btn_s1  <= btn_n;
            r_btn_s2  <= r_btn_s1;
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

    // Counter only runs while the synchronized input disagrees with the debounced value
    assign w_btn_diff = (r_btn_s2 != r_btn_db);
    assign w_db_tc    = (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_press    = w_btn_diff & w_db_tc & r_btn_db;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (!w_btn_diff) begin
            r_db_cnt <= '0;
        end else if (w_db_tc) begin
            r_btn_db <= r_btn_s2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    assign w_settle_tc = (r_wait_cnt == WAIT_W'(SETTLE_CYCLES - 1));
    assign w_lock_tc   = (r_wait_cnt == WAIT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_mode_adv  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_START: begin
                w_state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_clr   = 1'b1;
            end
            ST_SETTLE: begin
                if (w_settle_tc) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout
                if (r_lock_s2) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (w_lock_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                    w_err_set   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_PULSE;
                    w_mode_adv  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_wait_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= 4'(INIT_INDEX);
        end else if (w_mode_adv) begin
            if (r_mode == 4'(NUM_MODES - 1)) begin
                r_mode <= 4'd0;
            end else begin
                r_mode <= r_mode + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_err <= 1'b0;
        end else if (w_err_set) begin
            r_lock_err <= 1'b1;
        end
    end

    assign mode        = r_mode;
    assign mode_change = (r_state == ST_PULSE);
    assign busy        = (r_state != ST_IDLE);
    assign lock_err    = r_lock_err;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: table of {inputs, cycles, expected outputs}
// records plus hand-written sequences for lock timeout and mid-sequence reset.
module tb_mode_sequencer;

    logic       clk_50;
    logic       reset_n;
    logic       btn_n;
    logic       pll_locked;
    logic [3:0] mode;
    logic       mode_change;
    logic       busy;
    logic       lock_err;

    int n_cmp  = 0;
    int n_fail = 0;

    mode_sequencer #(
        .NUM_MODES      (6),
        .INIT_INDEX     (0),
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (4),
        .LOCK_TIMEOUT   (20)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .pll_locked (pll_locked),
        .mode       (mode),
        .mode_change(mode_change),
        .busy       (busy),
        .lock_err   (lock_err)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    typedef struct {
        int   hand;
        logic btn;
        logic lock;
        int   n;
        int   mode;
        int   pulses;
        int   busy;
        int   err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic b, input logic l, input int n,
                                input int m, input int p, input int bz, input int e);
        vec_t v;
        v.hand = 0; v.btn = b; v.lock = l; v.n = n;
        v.mode = m; v.pulses = p; v.busy = bz; v.err = e;
        tbl.push_back(v);
    endfunction

    function automatic void add_hand(input int k);
        vec_t v;
        v.hand = k; v.btn = 1'b1; v.lock = 1'b1; v.n = 0;
        v.mode = 0; v.pulses = 0; v.busy = 0; v.err = 0;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic wait_pulse(output bit found);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (mode_change) found = 1'b1;
        end
    endtask

    // Press with lock held low, then reset while waiting for lock at mode 3
    task automatic hand_reset_mid();
        bit f;
        pll_locked = 1'b0;
        btn_n      = 1'b0;
        wait_pulse(f);
        chk("r35 pulse seen", int'(f), 1);
        chk("r35 mode before reset", int'(mode), 3);
        btn_n = 1'b1;
        repeat (6) step();
        chk("r35 busy in wait_lock", int'(busy), 1);
        reset_n = 1'b0;
        #2;
        chk("r35 mode in reset", int'(mode), 0);
        chk("r35 mode_change in reset", int'(mode_change), 0);
        chk("r35 busy in reset", int'(busy), 1);
        chk("r35 lock_err in reset", int'(lock_err), 0);
        pll_locked = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        #2;
        chk("r35 mode_change 1st cycle", int'(mode_change), 0);
        step();
        chk("r35 mode_change 2nd cycle", int'(mode_change), 1);
        chk("r35 mode after release", int'(mode), 0);
        step();
        chk("r35 mode_change 3rd cycle", int'(mode_change), 0);
        repeat (6) step();
        chk("r35 busy after lock", int'(busy), 0);
        chk("r35 lock_err after lock", int'(lock_err), 0);
    endtask

    // WAIT_LOCK entered 5 cycles after the pulse cycle; timeout 20 cycles later
    task automatic hand_lock_timeout();
        bit f;
        pll_locked = 1'b0;
        btn_n      = 1'b0;
        wait_pulse(f);
        chk("r33 pulse seen", int'(f), 1);
        chk("r33 mode", int'(mode), 1);
        btn_n = 1'b1;
        repeat (24) step();
        chk("r33 lock_err before timeout", int'(lock_err), 0);
        chk("r33 busy before timeout", int'(busy), 1);
        step();
        chk("r33 lock_err at timeout", int'(lock_err), 1);
        chk("r33 busy at timeout", int'(busy), 0);
        chk("r33 mode held", int'(mode), 1);
        pll_locked = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_n      = 1'b1;
        pll_locked = 1'b1;

        // Startup with lock present
        add(1, 1, 10, 0, 1, 0, 0);
        // Five presses walk the mode up to 5
        for (int m = 1; m <= 5; m++) begin
            add(0, 1, 14, m, 1, 0, 0);
            add(1, 1, 8,  m, 0, 0, 0);
        end
        // Wrap 5 -> 0 with a 10-cycle hold
        add(0, 1, 10, 0, 1, 1, 0);
        add(1, 1, 8,  0, 0, 0, 0);
        // Bounce every 2 cycles: never stable long enough
        for (int k = 0; k < 5; k++) begin
            add(0, 1, 2, 0, 0, 0, 0);
            add(1, 1, 2, 0, 0, 0, 0);
        end
        add(1, 1, 8, 0, 0, 0, 0);
        // Second press while busy is dropped, third press after IDLE advances
        add(0, 0, 7,  1, 1, 1, 0);
        add(1, 0, 6,  1, 0, 1, 0);
        add(0, 0, 8,  1, 0, 1, 0);
        add(1, 1, 8,  1, 0, 0, 0);
        add(0, 1, 14, 2, 1, 0, 0);
        add(1, 1, 8,  2, 0, 0, 0);
        add_hand(1);
        add_hand(2);
        // lock_err is sticky across a later successful lock
        add(0, 1, 14, 2, 1, 0, 1);
        add(1, 1, 8,  2, 0, 0, 1);

        repeat (3) step();
        chk("reset mode", int'(mode), 0);
        chk("reset mode_change", int'(mode_change), 0);
        chk("reset busy", int'(busy), 1);
        chk("reset lock_err", int'(lock_err), 0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].hand == 1) begin
                hand_reset_mid();
            end else if (tbl[i].hand == 2) begin
                hand_lock_timeout();
            end else begin
                int pulses;
                pulses     = 0;
                btn_n      = tbl[i].btn;
                pll_locked = tbl[i].lock;
                for (int c = 0; c < tbl[i].n; c++) begin
                    step();
                    if (mode_change) pulses++;
                end
                chk($sformatf("v%0d mode", i), int'(mode), tbl[i].mode);
                chk($sformatf("v%0d pulses", i), pulses, tbl[i].pulses);
                chk($sformatf("v%0d busy", i), int'(busy), tbl[i].busy);
                chk($sformatf("v%0d lock_err", i), int'(lock_err), tbl[i].err);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1);
    end

endmodule
